// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU control codes, opcodes and issue-stage state encoding
package alu_pkg;

   localparam logic [5:0] CS_AND  = 6'b100100;
   localparam logic [5:0] CS_OR   = 6'b100101;
   localparam logic [5:0] CS_ADD  = 6'b100000;
   localparam logic [5:0] CS_SUB  = 6'b100010;
   localparam logic [5:0] CS_MULT = 6'b011000;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/alu_decode.sv
// rtl/alu_decode.sv - combinational MIPS decode to ALU operands, control code and destination
module alu_decode
   import alu_pkg::*;
(
   input  logic [31:0] instr,
   input  logic [31:0] rs_data,
   input  logic [31:0] rt_data,
   output logic [31:0] a,
   output logic [31:0] b,
   output logic [5:0]  cs,
   output logic [4:0]  dest,
   output logic        illegal
);

   // Register-number and shamt fields are resolved upstream by the register file.
   logic w_unused_fields;
   assign w_unused_fields = ^{instr[25:21], instr[10:6]};

   always_comb begin
      a       = rs_data;
      b       = rt_data;
      cs      = CS_ADD;
      dest    = 5'd0;
      illegal = 1'b1;
      case (instr[31:26])
         OP_RTYPE: begin
            case (instr[5:0])
               CS_AND, CS_OR, CS_ADD, CS_SUB, CS_MULT: begin
                  cs      = instr[5:0];
                  dest    = instr[15:11];
                  illegal = 1'b0;
               end
               default: ;
            endcase
         end
         OP_ADDI: begin
            cs      = CS_ADD;
            b       = {{16{instr[15]}}, instr[15:0]};
            dest    = instr[20:16];
            illegal = 1'b0;
         end
         OP_ANDI: begin
            cs      = CS_AND;
            b       = {16'h0000, instr[15:0]};
            dest    = instr[20:16];
            illegal = 1'b0;
         end
         OP_ORI: begin
            cs      = CS_OR;
            b       = {16'h0000, instr[15:0]};
            dest    = instr[20:16];
            illegal = 1'b0;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - valid/ready issue stage driving an external combinational ALU
module alu_issue
   import alu_pkg::*;
#(
   parameter int ALU_LAT = 1,
   parameter int CNT_W   = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] instr,
   input  logic [31:0] rs_data,
   input  logic [31:0] rt_data,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [5:0]  alu_cs,
   input  logic [31:0] alu_result,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_result,
   output logic        out_zero,
   output logic [4:0]  out_dest,
   output logic        out_illegal
);

   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(ALU_LAT - 1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [31:0]      r_alu_a;
   logic [31:0]      r_alu_b;
   logic [5:0]       r_alu_cs;
   logic             r_out_valid;
   logic [31:0]      r_out_result;
   logic             r_out_zero;
   logic [4:0]       r_out_dest;
   logic             r_out_illegal;

   logic [31:0]      w_dec_a;
   logic [31:0]      w_dec_b;
   logic [5:0]       w_dec_cs;
   logic [4:0]       w_dec_dest;
   logic             w_dec_illegal;
   logic             w_accept;

   alu_decode u_decode (
      .instr   (instr),
      .rs_data (rs_data),
      .rt_data (rt_data),
      .a       (w_dec_a),
      .b       (w_dec_b),
      .cs      (w_dec_cs),
      .dest    (w_dec_dest),
      .illegal (w_dec_illegal)
   );

   assign in_ready    = (r_state == ST_IDLE);
   assign w_accept    = in_valid & in_ready;
   assign alu_a       = r_alu_a;
   assign alu_b       = r_alu_b;
   assign alu_cs      = r_alu_cs;
   assign out_valid   = r_out_valid;
   assign out_result  = r_out_result;
   assign out_zero    = r_out_zero;
   assign out_dest    = r_out_dest;
   assign out_illegal = r_out_illegal;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (w_accept) w_state_nxt = w_dec_illegal ? ST_DONE : ST_EXEC;
         ST_EXEC: if (r_cnt == '0) w_state_nxt = ST_DONE;
         ST_DONE: if (r_out_valid && out_ready) w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // An illegal instruction spends one cycle in DONE with out_valid low, so it
   // reports with the same one-cycle latency as the shortest legal operation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt         <= '0;
         r_alu_a       <= 32'd0;
         r_alu_b       <= 32'd0;
         r_alu_cs      <= CS_ADD;
         r_out_valid   <= 1'b0;
         r_out_result  <= 32'd0;
         r_out_zero    <= 1'b0;
         r_out_dest    <= 5'd0;
         r_out_illegal <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_out_dest <= w_dec_dest;
                  if (w_dec_illegal) begin
                     r_out_result  <= 32'd0;
                     r_out_zero    <= 1'b1;
                     r_out_illegal <= 1'b1;
                  end else begin
                     r_alu_a  <= w_dec_a;
                     r_alu_b  <= w_dec_b;
                     r_alu_cs <= w_dec_cs;
                     r_cnt    <= CNT_INIT;
                  end
               end
            end
            ST_EXEC: begin
               if (r_cnt == '0) begin
                  r_out_result  <= alu_result;
                  r_out_zero    <= (alu_result == 32'd0);
                  r_out_illegal <= 1'b0;
                  r_out_valid   <= 1'b1;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            ST_DONE: begin
               if (!r_out_valid) begin
                  r_out_valid <= 1'b1;
               end else if (out_ready) begin
                  r_out_valid <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
